// File: rtl/pipe_pkg.sv
// Shared pipeline types: op-class codes, forward FSM states and
// operand-select encodings.
package pipe_pkg;

   localparam logic [1:0] OP_ALU = 2'b10;
   localparam logic [1:0] OP_LD  = 2'b00;

   typedef enum logic {
      RUN,
      BUBBLE
   } fwd_state_t;

   typedef enum logic [1:0] {
      SEL_RF,
      SEL_R3,
      SEL_R4
   } sel_t;

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forward qualification, r0 mask and priority.
// Outputs the chosen source; the data mux lives in the caller.
module fwd_sel
   import pipe_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             d4_i,
   input  logic             t4_i,
   input  logic             d3_i,
   input  logic [1:0]       op3_i,
   input  logic [1:0]       op4_i,
   input  logic [REG_W-1:0] src_i,
   output sel_t             sel_o
);

   logic nz;
   logic use3;
   logic use4;

   always_comb begin
      nz   = (src_i != '0);
      // detector flags can be stale, so trust them only with a matching producer
      use3 = d3_i && (op3_i == OP_ALU) && nz;
      use4 = ((t4_i && (op4_i == OP_LD)) ||
              (d4_i && (op4_i == OP_ALU))) && nz;
      sel_o = SEL_RF;
      if (use3) begin
         sel_o = SEL_R3;
      end else if (use4) begin
         sel_o = SEL_R4;
      end
   end

endmodule

// File: rtl/operand_forward.sv
// Stage-2 operand select, ID/EX operand register and load-use interlock.
// Optional statistics counters enabled by OPFWD_STATS_EN.
module operand_forward
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              has2d4,
   input  logic              has2t4,
   input  logic              has2d3,
   input  logic              hbt2d4,
   input  logic              hbt2t4,
   input  logic              hbt2d3,
   input  logic [1:0]        alu_op2,
   input  logic [1:0]        alu_op3,
   input  logic [1:0]        alu_op4,
   input  logic [REG_W-1:0]  rs2,
   input  logic [REG_W-1:0]  rt2,
   input  logic [REG_W-1:0]  rt3,
   input  logic [DATA_W-1:0] rf_a2,
   input  logic [DATA_W-1:0] rf_b2,
   input  logic [DATA_W-1:0] res3,
   input  logic [DATA_W-1:0] res4,
   input  logic              hold,
   output logic [DATA_W-1:0] op_a3,
   output logic [DATA_W-1:0] op_b3,
   output logic              op_valid3,
`ifdef OPFWD_STATS_EN
   output logic [15:0]       fwd_cnt,
   output logic [15:0]       stall_cnt,
`endif
   output logic              stall
);

   fwd_state_t        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0] mux_a, mux_b;
   logic              v_q, v_d;
   logic              hazard;
   logic              cap;
   logic              go_bub;
   sel_t              sel_a, sel_b;

   fwd_sel #(.REG_W(REG_W)) u_sel_a (
      .d4_i (has2d4),
      .t4_i (has2t4),
      .d3_i (has2d3),
      .op3_i(alu_op3),
      .op4_i(alu_op4),
      .src_i(rs2),
      .sel_o(sel_a)
   );

   fwd_sel #(.REG_W(REG_W)) u_sel_b (
      .d4_i (hbt2d4),
      .t4_i (hbt2t4),
      .d3_i (hbt2d3),
      .op3_i(alu_op3),
      .op4_i(alu_op4),
      .src_i(rt2),
      .sel_o(sel_b)
   );

   always_comb begin
      unique case (sel_a)
         SEL_R3:  mux_a = res3;
         SEL_R4:  mux_a = res4;
         default: mux_a = rf_a2;
      endcase
      unique case (sel_b)
         SEL_R3:  mux_b = res3;
         SEL_R4:  mux_b = res4;
         default: mux_b = rf_b2;
      endcase
   end

   always_comb begin
      hazard = (alu_op2 == OP_ALU) && (alu_op3 == OP_LD) &&
               (rt3 != '0) && ((rt3 == rs2) || (rt3 == rt2));
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      v_d     = v_q;
      stall   = 1'b0;
      cap     = 1'b0;
      go_bub  = 1'b0;
      if (!rst_n) begin
         stall = 1'b0;
      end else if (hold) begin
         stall = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (hazard) begin
                  stall   = 1'b1;
                  go_bub  = 1'b1;
                  state_d = BUBBLE;
                  v_d     = 1'b0;
               end else begin
                  cap = 1'b1;
               end
            end
            BUBBLE: begin
               state_d = RUN;
               cap     = 1'b1;
            end
            default: state_d = RUN;
         endcase
         if (cap) begin
            a_d = mux_a;
            b_d = mux_b;
            v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         a_q     <= '0;
         b_q     <= '0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         v_q     <= v_d;
      end
   end

   assign op_a3     = a_q;
   assign op_b3     = b_q;
   assign op_valid3 = v_q;

`ifdef OPFWD_STATS_EN
   logic [15:0] fc_q, fc_d, sc_q, sc_d;
   logic        fwd_any;

   always_comb begin
      fwd_any = (sel_a != SEL_RF) || (sel_b != SEL_RF);
      fc_d    = fc_q;
      sc_d    = sc_q;
      if (cap && fwd_any && (fc_q != 16'hFFFF)) begin
         fc_d = fc_q + 16'd1;
      end
      if (go_bub && (sc_q != 16'hFFFF)) begin
         sc_d = sc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fc_q <= '0;
         sc_q <= '0;
      end else begin
         fc_q <= fc_d;
         sc_q <= sc_d;
      end
   end

   assign fwd_cnt   = fc_q;
   assign stall_cnt = sc_q;
`else
   logic unused_ok;
   assign unused_ok = go_bub;
`endif

endmodule

// File: doc/operand_forward.md
# operand_forward

Stage-2 operand selection and load-use interlock for the 5-stage pipeline. Consumes the six per-operand forwarding flags from `HazardDetector`, qualifies them against the producer opcodes, and selects the stage-3 ALU operands from the register file, the stage-3 result or the stage-4 result. It registers those operands into the stage-2/3 pipeline register. When a load in stage 3 feeds an ALU op in stage 2, it stalls the front end for one cycle and inserts a bubble.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register-specifier width
- `clk` in 1: pipeline clock
- `rst_n` in 1: synchronous reset, active-low
- `has2d4`, `has2t4`, `has2d3` in 1 each: operand-A forward flags from `HazardDetector`
- `hbt2d4`, `hbt2t4`, `hbt2d3` in 1 each: operand-B forward flags from `HazardDetector`
- `alu_op2`, `alu_op3`, `alu_op4` in 2 each: op class per stage; 2'b10 = ALU, 2'b00 = LD
- `rs2`, `rt2`, `rt3` in REG_W each: stage-2 sources; stage-3 load destination
- `rf_a2`, `rf_b2` in DATA_W each: register-file read data
- `res3` in DATA_W: stage-3 ALU result
- `res4` in DATA_W: stage-4 result (ALU result or load data)
- `hold` in 1: global freeze (memory wait)
- `op_a3`, `op_b3` out DATA_W each: registered operands to stage 3
- `op_valid3` out 1: stage-3 slot holds a real instruction (0 = bubble)
- `stall` out 1: freeze PC and IF/ID this cycle
- `fwd_cnt`, `stall_cnt` out 16 each: present only with `OPFWD_STATS_EN`

## Operation
- Forward flags are level-sensitive from the detector and may hold stale values, so every flag is re-qualified here:
  - d3 is used only if `alu_op3`==10
  - t4 is used only if `alu_op4`==00
  - d4 is used only if `alu_op4`==10
- A forward is suppressed when the matching source specifier (`rs2` for A, `rt2` for B) is 0; r0 always reads `rf_*2`.
- Priority per operand: qualified d3 selects `res3`, else qualified t4 or d4 selects `res4`, else `rf_*2`.
- Load-use hazard: `alu_op2`==10, `alu_op3`==00, `rt3`!=0, and (`rt3`==`rs2` or `rt3`==`rt2`).
- FSM states:
  - RUN: on a load-use hazard with `hold`=0, go to BUBBLE. `stall`=1 combinationally in that same cycle; the capture writes a bubble (`op_valid3`<=0, operands unchanged).
  - BUBBLE: `stall`=0. Capture normally, since the load is now in stage 4 and is forwarded via t4. Return to RUN.
- `hold`=1 freezes the FSM state and all output registers, and forces `stall`=1. A hazard pending under `hold` is evaluated when `hold` drops.

## Timing
- Operand latency is 1 cycle: select in cycle N, visible on `op_a3`/`op_b3` in N+1.
- `stall` is combinational from the current-cycle inputs and state. A load-use hazard costs exactly 1 bubble.
- Reset values: `op_a3`=0, `op_b3`=0, `op_valid3`=0, state=RUN, counters=0. `stall`=0 while `rst_n`=0.
- Reset asserted in BUBBLE aborts the stall; the next cycle is RUN with `op_valid3`=0.
- Back-to-back loads each feeding the next ALU op stall once per pair. No stall is issued from the BUBBLE state.

## Configuration
- `OPFWD_STATS_EN` defined:
  - `fwd_cnt` increments once per non-hold, non-bubble capture in which either operand was forwarded.
  - `stall_cnt` increments on each RUN→BUBBLE transition.
  - Both are 16-bit and saturate at 16'hFFFF.
- Not defined: the counter ports and their logic are absent.

## Structure
- Shared package `pipe_pkg`:
  - op-class constants `OP_ALU`=2'b10 and `OP_LD`=2'b00
  - FSM state enum `fwd_state_t`
  - operand-select enum: `SEL_RF`, `SEL_R3`, `SEL_R4`
- One sub-module, `fwd_sel`: purely combinational qualify, r0-mask and priority for a single operand, instantiated twice (A and B).

## Test plan
- `has2d3`=1, `alu_op3`=10, `rs2`=5, `res3`=32'h11 → `op_a3`=32'h11 next cycle, `op_valid3`=1, `stall`=0.
- `has2d3`=1, `has2d4`=1, both qualified, `res3`=1, `res4`=2 → `op_a3`=1 (d3 priority).
- Stale `hbt2t4`=1 with `alu_op4`=10, `hbt2d4`=0 → `op_b3`=`rf_b2` (flag disqualified).
- `rs2`=0 with `has2d3`=1 qualified → `op_a3`=`rf_a2`.
- Load-use, `rt3`=7=`rt2` → `stall`=1 for one cycle and a bubble (`op_valid3`=0). The next capture takes `res4` on B via t4; `stall_cnt`=1 when the macro is defined.
- Hazard present with `hold`=1 for 3 cycles → outputs frozen and `stall`=1 throughout; the bubble occurs after `hold` drops.
